// File: rtl/serial_magnitude_comparator_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cmp_pkg
//  Description : Shared types and sizing helpers for the serial magnitude
//                comparator (FSM state encoding, slice count, counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of 2-bit slices in an operand of the given width.
   function automatic int slices(input int width);
      return width / 2;
   endfunction

   // Slice counter width; a single slice still needs a 1-bit counter.
   function automatic int cnt_width(input int nslice);
      return (nslice <= 1) ? 1 : $clog2(nslice);
   endfunction

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/serial_magnitude_comparator_slice.sv
`default_nettype none
// ============================================================================
//  Module      : slice_cmp_2bit
//  Description : Combinational 2-bit unsigned comparator producing an
//                equality flag and an a-greater-than-b flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module slice_cmp_2bit (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic       eq,
   output logic       gt
);

   // Equality written as the four matching minterms; gt decided on bit 1,
   // falling back to bit 0 when the upper bits match.
   always_comb begin
      eq = (~a[1] & ~b[1] & ~a[0] & ~b[0]) |
           (~a[1] & ~b[1] &  a[0] &  b[0]) |
           ( a[1] &  b[1] & ~a[0] & ~b[0]) |
           ( a[1] &  b[1] &  a[0] &  b[0]);
      gt = (a[1] & ~b[1]) | ((a[1] ~^ b[1]) & a[0] & ~b[0]);
   end

endmodule : slice_cmp_2bit
`default_nettype wire

// File: rtl/serial_magnitude_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : serial_magnitude_comparator
//  Description : Sequential unsigned magnitude comparator. Scans the operands
//                MSB-first one 2-bit slice per clock, exits early on the
//                first unequal slice and returns a one-hot {agtb,aeqb,altb}
//                result over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_magnitude_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             agtb,
   output logic             aeqb,
   output logic             altb,
   output logic             busy
);

   localparam int NSLICE = slices(WIDTH);
   localparam int CW     = cnt_width(NSLICE);

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_a_sh, w_a_sh_nxt;
   logic [WIDTH-1:0] r_b_sh, w_b_sh_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic             r_res_valid, w_res_valid_nxt;
   logic             r_agtb, w_agtb_nxt;
   logic             r_aeqb, w_aeqb_nxt;
   logic             r_altb, w_altb_nxt;
   logic             r_busy, w_busy_nxt;
   logic             w_eq;
   logic             w_gt;

   // Compare the current most-significant slice of the shifted operands.
   slice_cmp_2bit u_slice (
      .a  (r_a_sh[WIDTH-1:WIDTH-2]),
      .b  (r_b_sh[WIDTH-1:WIDTH-2]),
      .eq (w_eq),
      .gt (w_gt)
   );

   // State register plus all registered outputs and datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_a_sh      <= '0;
         r_b_sh      <= '0;
         r_cnt       <= '0;
         r_res_valid <= 1'b0;
         r_agtb      <= 1'b0;
         r_aeqb      <= 1'b0;
         r_altb      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_a_sh      <= w_a_sh_nxt;
         r_b_sh      <= w_b_sh_nxt;
         r_cnt       <= w_cnt_nxt;
         r_res_valid <= w_res_valid_nxt;
         r_agtb      <= w_agtb_nxt;
         r_aeqb      <= w_aeqb_nxt;
         r_altb      <= w_altb_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   // Next-state and next-output decode; everything holds unless changed.
   always_comb begin
      w_state_nxt     = r_state;
      w_a_sh_nxt      = r_a_sh;
      w_b_sh_nxt      = r_b_sh;
      w_cnt_nxt       = r_cnt;
      w_res_valid_nxt = r_res_valid;
      w_agtb_nxt      = r_agtb;
      w_aeqb_nxt      = r_aeqb;
      w_altb_nxt      = r_altb;
      w_busy_nxt      = r_busy;
      case (r_state)
         IDLE: begin
            if (start_valid) begin
               w_a_sh_nxt  = a;
               w_b_sh_nxt  = b;
               w_cnt_nxt   = CW'(NSLICE - 1);
               w_busy_nxt  = 1'b1;
               w_state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (!w_eq) begin
               // First differing slice fully decides the ordering.
               w_agtb_nxt      = w_gt;
               w_altb_nxt      = ~w_gt;
               w_aeqb_nxt      = 1'b0;
               w_res_valid_nxt = 1'b1;
               w_state_nxt     = DONE;
            end else if (r_cnt == '0) begin
               w_aeqb_nxt      = 1'b1;
               w_res_valid_nxt = 1'b1;
               w_state_nxt     = DONE;
            end else begin
               w_a_sh_nxt = r_a_sh << 2;
               w_b_sh_nxt = r_b_sh << 2;
               w_cnt_nxt  = r_cnt - CW'(1);
            end
         end
         DONE: begin
            if (res_ready) begin
               w_res_valid_nxt = 1'b0;
               w_agtb_nxt      = 1'b0;
               w_aeqb_nxt      = 1'b0;
               w_altb_nxt      = 1'b0;
               w_busy_nxt      = 1'b0;
               w_state_nxt     = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign start_ready = (r_state == IDLE);
   assign res_valid   = r_res_valid;
   assign agtb        = r_agtb;
   assign aeqb        = r_aeqb;
   assign altb        = r_altb;
   assign busy        = r_busy;

endmodule : serial_magnitude_comparator
`default_nettype wire

// File: tb/tb_serial_magnitude_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_magnitude_comparator
//  Description : Self-checking bench for the serial magnitude comparator,
//                WIDTH=8 and WIDTH=2 instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_magnitude_comparator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       sv, sr, rv, rr, gt, eq, lt, bsy;
   logic [7:0] a, b;
   logic       sv2, sr2, rv2, rr2, gt2, eq2, lt2, bsy2;
   logic [1:0] a2, b2;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] flags;   // {agtb, aeqb, altb}
      int         lat;
      int         hold;
      bit         pulse;
   } vec_t;

   vec_t tbl [10];

   always #5 clk = ~clk;

   serial_magnitude_comparator #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start_valid(sv), .start_ready(sr),
      .a(a), .b(b), .res_valid(rv), .res_ready(rr),
      .agtb(gt), .aeqb(eq), .altb(lt), .busy(bsy)
   );

   serial_magnitude_comparator #(.WIDTH(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start_valid(sv2), .start_ready(sr2),
      .a(a2), .b(b2), .res_valid(rv2), .res_ready(rr2),
      .agtb(gt2), .aeqb(eq2), .altb(lt2), .busy(bsy2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Latency model: 1-based index of the first differing slice, MSB first.
   function automatic int klat(input logic [7:0] x, input logic [7:0] y, input int ns);
      for (int s = 0; s < ns; s++)
         if (x[2*(ns-1-s) +: 2] != y[2*(ns-1-s) +: 2]) return s + 1;
      return ns;
   endfunction

   function automatic logic [2:0] kflags(input logic [7:0] x, input logic [7:0] y);
      if (x > y) return 3'b100;
      if (x == y) return 3'b010;
      return 3'b001;
   endfunction

   task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] ef,
                       input int el, input int hold, input bit pulse);
      int lat;
      for (int i = 0; i < 20 && !sr; i++) begin @(posedge clk); #1; end
      chk("w8_start_ready_idle", sr, 1);
      a = va; b = vb; sv = 1'b1;
      @(posedge clk); #1;
      sv = 1'b0; a = 8'($urandom); b = 8'($urandom);
      chk("w8_busy_scan", {bsy, sr, rv}, 3'b100);
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!rv && lat < 6);
      chk("w8_latency", lat, el);
      chk("w8_res_valid", rv, 1);
      chk("w8_flags", {gt, eq, lt}, ef);
      chk("w8_start_ready_done", sr, 0);
      for (int i = 0; i < hold; i++) begin
         if (pulse && i == 0) begin sv = 1'b1; a = ~va; b = vb; end
         @(posedge clk); #1;
         sv = 1'b0;
         chk("w8_hold_flags", {rv, gt, eq, lt, sr, bsy}, {1'b1, ef, 1'b0, 1'b1});
      end
      rr = 1'b1;
      @(posedge clk); #1;
      rr = 1'b0;
      chk("w8_cleared", {rv, gt, eq, lt, bsy, sr}, 6'b000001);
   endtask

   task automatic run2(input logic [1:0] va, input logic [1:0] vb, input int hold);
      logic [2:0] ef;
      ef = kflags({6'd0, va}, {6'd0, vb});
      for (int i = 0; i < 20 && !sr2; i++) begin @(posedge clk); #1; end
      chk("w2_start_ready_idle", sr2, 1);
      a2 = va; b2 = vb; sv2 = 1'b1;
      @(posedge clk); #1;
      sv2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
      chk("w2_scan", {bsy2, rv2}, 2'b10);
      @(posedge clk); #1;
      chk("w2_latency1_valid", rv2, 1);
      chk("w2_flags", {gt2, eq2, lt2}, ef);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("w2_hold", {rv2, gt2, eq2, lt2, sr2}, {1'b1, ef, 1'b0});
      end
      rr2 = 1'b1;
      @(posedge clk); #1;
      rr2 = 1'b0;
      chk("w2_cleared", {rv2, gt2, eq2, lt2, bsy2, sr2}, 6'b000001);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] ra, rb;
      int s;

      tbl[0] = '{8'hA5, 8'hA5, 3'b010, 4, 0, 1'b0};
      tbl[1] = '{8'hC0, 8'h80, 3'b100, 1, 0, 1'b0};
      tbl[2] = '{8'h12, 8'h13, 3'b001, 4, 0, 1'b0};
      tbl[3] = '{8'h40, 8'h80, 3'b001, 1, 5, 1'b1};
      tbl[4] = '{8'h00, 8'h00, 3'b010, 4, 1, 1'b0};
      tbl[5] = '{8'hFF, 8'h00, 3'b100, 1, 0, 1'b0};
      tbl[6] = '{8'h34, 8'h38, 3'b001, 3, 2, 1'b1};
      tbl[7] = '{8'hE7, 8'hE4, 3'b100, 4, 0, 1'b0};
      tbl[8] = '{8'h2F, 8'h1F, 3'b100, 2, 1, 1'b0};
      tbl[9] = '{8'hFF, 8'hFF, 3'b010, 4, 3, 1'b1};

      sv = 0; rr = 0; a = '0; b = '0;
      sv2 = 0; rr2 = 0; a2 = '0; b2 = '0;

      // Reset values.
      #1;
      chk("rst8_outputs", {rv, gt, eq, lt, bsy, sr}, 6'b000001);
      chk("rst2_outputs", {rv2, gt2, eq2, lt2, bsy2, sr2}, 6'b000001);
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst8_idle", {rv, bsy, sr}, 3'b001);

      // Directed table.
      foreach (tbl[i]) run8(tbl[i].a, tbl[i].b, tbl[i].flags, tbl[i].lat, tbl[i].hold, tbl[i].pulse);

      // Asynchronous reset in the middle of a scan.
      a = 8'hFF; b = 8'hFE; sv = 1'b1;
      @(posedge clk); #1;
      sv = 1'b0;
      @(posedge clk); #3;
      chk("mid_scan_busy", bsy, 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_outputs", {rv, gt, eq, lt, bsy, sr}, 6'b000001);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      run8(8'hFF, 8'hFE, 3'b100, 4, 0, 1'b0);

      // Random requests, WIDTH=8, biased toward long common prefixes.
      for (int n = 0; n < 1000; n++) begin
         ra = 8'($urandom);
         s  = int'($urandom_range(0, 4));
         rb = ra;
         if (s < 4) begin
            rb[2*(3-s) +: 2] = ra[2*(3-s) +: 2] ^ 2'($urandom_range(1, 3));
            for (int j = s + 1; j < 4; j++) rb[2*(3-j) +: 2] = 2'($urandom);
         end
         run8(ra, rb, kflags(ra, rb), klat(ra, rb, 4), int'($urandom_range(0, 3)),
              1'($urandom));
      end

      // Random requests, WIDTH=2.
      for (int n = 0; n < 1000; n++)
         run2(2'($urandom), 2'($urandom), int'($urandom_range(0, 3)));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_serial_magnitude_comparator
`default_nettype wire
